// File: rtl/mult_shift_add_if.sv
// Operand/result bundle between the pipeline controller and the shift-and-add multiplier.
// Handshake: start is taken on any rising edge while busy=0; busy then stays high until the
// product is ready, and done pulses for one cycle when hi/lo carry the new product.
interface mult_shift_add_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       fsm_state;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, hi, lo, fsm_state
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, hi, lo, fsm_state
  );
endinterface

// File: rtl/mult_shift_add.sv
// Multi-cycle shift-and-add multiplier for MULT/MULTU. Operates on operand magnitudes,
// one add-and-shift step per cycle, then applies the sign in a dedicated cycle.
module mult_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_shift_add_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        ONE_C = CW'(1);
  localparam logic [WIDTH-1:0]     ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_P = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Magnitude stays WIDTH-bit unsigned, so the most-negative value maps onto itself.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    prod     = {acc, mplier};
    prod_fix = neg ? (~prod + ONE_P) : prod;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand  <= mag(bus.op_a, bus.is_signed);
            mplier <= mag(bus.op_b, bus.is_signed);
            acc    <= '0;
            cnt    <= '0;
            neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          end
        end
        RUN: begin
          // Carry-out of the add lands in acc's MSB; acc's LSB shifts into mplier.
          {acc, mplier} <= {sum, mplier[WIDTH-1:1]};
          cnt           <= cnt + ONE_C;
        end
        SIGN: begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN) || (state == SIGN);
  assign bus.done      = (state == DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.fsm_state = state;

endmodule
